// File: rtl/btb_pkg.sv
// Shared types and helpers for the set-associative branch target buffer.
package btb_pkg;

  localparam int unsigned BTB_CTR_W = 2;
  localparam int unsigned BTB_PC_W  = 32;
  // Widest tag any legal geometry needs (SETS >= 2); narrower tags are zero-extended.
  localparam int unsigned BTB_TAG_W = BTB_PC_W - 3;

  typedef logic [BTB_CTR_W-1:0] ctr_t;

  localparam ctr_t CTR_RESET = 2'b01;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [BTB_PC_W-1:0]  target;
    ctr_t                 ctr;
  } btb_entry_t;

  function automatic ctr_t sat_inc(input ctr_t c);
    return (c == '1) ? c : ctr_t'(c + 1'b1);
  endfunction

  function automatic ctr_t sat_dec(input ctr_t c);
    return (c == '0) ? c : ctr_t'(c - 1'b1);
  endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// Fetch-lookup / execute-update bus between the pipeline and the BTB.
interface btb_assoc_if;
  import btb_pkg::*;

  logic [BTB_PC_W-1:0] lookup_pc;
  logic                pred_hit;
  logic                pred_taken;
  logic [BTB_PC_W-1:0] pred_target;
  logic                update_valid;
  logic [BTB_PC_W-1:0] update_pc;
  logic [BTB_PC_W-1:0] update_target;
  logic                update_taken;
  logic                flush;

  modport master (
    output lookup_pc, update_valid, update_pc, update_target, update_taken, flush,
    input  pred_hit, pred_taken, pred_target
  );

  modport slave (
    input  lookup_pc, update_valid, update_pc, update_target, update_taken, flush,
    output pred_hit, pred_taken, pred_target
  );
endinterface

// File: rtl/btb_plru.sv
// Per-set tree pseudo-LRU: touch marks a way most-recently-used, victim names the way to evict.
module btb_plru #(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned SETS  = 64,
  localparam int unsigned IDX_W = $clog2(SETS),
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             touch_en,
  input  logic [IDX_W-1:0] touch_set,
  input  logic [WAY_W-1:0] touch_way,
  input  logic [IDX_W-1:0] victim_set,
  output logic [WAY_W-1:0] victim_way_c
);

  if (WAYS == 1) begin : g_none
    assign victim_way_c = '0;
  end else if (WAYS == 2) begin : g_two
    // Bit holds the way to evict next.
    logic state_q [SETS];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < SETS; s++) state_q[s] <= 1'b0;
      end else if (clr) begin
        for (int s = 0; s < SETS; s++) state_q[s] <= 1'b0;
      end else if (touch_en) begin
        state_q[touch_set] <= ~touch_way[0];
      end
    end

    assign victim_way_c = state_q[victim_set];
  end else begin : g_four
    // [0] picks the pair, [1] the way in pair {0,1}, [2] the way in pair {2,3}.
    logic [2:0] state_q [SETS];
    logic [2:0] next_c;
    logic [2:0] vic_c;

    always_comb begin
      next_c    = state_q[touch_set];
      next_c[0] = ~touch_way[1];
      if (touch_way[1]) next_c[2] = ~touch_way[0];
      else              next_c[1] = ~touch_way[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < SETS; s++) state_q[s] <= '0;
      end else if (clr) begin
        for (int s = 0; s < SETS; s++) state_q[s] <= '0;
      end else if (touch_en) begin
        state_q[touch_set] <= next_c;
      end
    end

    assign vic_c        = state_q[victim_set];
    assign victim_way_c = vic_c[0] ? {1'b1, vic_c[2]} : {1'b0, vic_c[1]};
  end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative tagged BTB with 2-bit direction counters, PLRU replacement and flush.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int unsigned SETS     = 64,
  parameter int unsigned WAYS     = 2,
  parameter ctr_t        CTR_INIT = 2'b10
) (
  input  logic        clk,
  input  logic        rst_n,
  btb_assoc_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  function automatic logic [BTB_TAG_W-1:0] tag_of(input logic [BTB_PC_W-1:0] pc);
    return BTB_TAG_W'(pc >> (IDX_W + 2));
  endfunction

  logic                 valid_q  [SETS][WAYS];
  ctr_t                 ctr_q    [SETS][WAYS];
  logic [BTB_TAG_W-1:0] tag_q    [SETS][WAYS];
  logic [BTB_PC_W-1:0]  target_q [SETS][WAYS];

  logic [IDX_W-1:0]     lk_idx, up_idx;
  logic [BTB_TAG_W-1:0] lk_tag, up_tag;
  btb_entry_t           lk_ent [WAYS];
  btb_entry_t           lk_sel;
  logic                 lk_hit;

  logic                 up_hit, inv_any, wr_en;
  logic [WAY_W-1:0]     up_way, inv_way, victim_c, wr_way;
  ctr_t                 wr_ctr;

  assign lk_idx = bus.lookup_pc[IDX_W+1:2];
  assign lk_tag = tag_of(bus.lookup_pc);
  assign up_idx = bus.update_pc[IDX_W+1:2];
  assign up_tag = tag_of(bus.update_pc);

  // Lookup reads the arrays before any same-cycle write lands.
  always_comb begin
    lk_hit = 1'b0;
    lk_sel = '0;
    for (int w = 0; w < WAYS; w++) begin
      lk_ent[w] = '{valid:  valid_q[lk_idx][w],
                    tag:    tag_q[lk_idx][w],
                    target: target_q[lk_idx][w],
                    ctr:    ctr_q[lk_idx][w]};
      if (lk_ent[w].valid && (lk_ent[w].tag == lk_tag)) begin
        lk_hit = 1'b1;
        lk_sel = lk_ent[w];
      end
    end
  end

  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin
    up_hit  = 1'b0;
    up_way  = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[up_idx][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
      if (valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag)) begin
        up_hit = 1'b1;
        up_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    wr_en  = bus.update_valid && !bus.flush && (up_hit || bus.update_taken);
    wr_way = up_hit ? up_way : (inv_any ? inv_way : victim_c);
    wr_ctr = CTR_INIT;
    if (up_hit) begin
      wr_ctr = bus.update_taken ? sat_inc(ctr_q[up_idx][up_way])
                                : sat_dec(ctr_q[up_idx][up_way]);
    end
  end

  btb_plru #(.WAYS(WAYS), .SETS(SETS)) u_plru (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (bus.flush),
    .touch_en     (wr_en),
    .touch_set    (up_idx),
    .touch_way    (wr_way),
    .victim_set   (up_idx),
    .victim_way_c (victim_c)
  );

  // Valid bits and counters; flush clears valids only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          ctr_q[s][w]   <= CTR_RESET;
        end
      end
    end else if (bus.flush) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
      end
    end else if (wr_en) begin
      valid_q[up_idx][wr_way] <= 1'b1;
      ctr_q[up_idx][wr_way]   <= wr_ctr;
    end
  end

  // Tag and target storage carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[up_idx][wr_way]    <= up_tag;
      target_q[up_idx][wr_way] <= bus.update_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.pred_hit    <= 1'b0;
      bus.pred_taken  <= 1'b0;
      bus.pred_target <= '0;
    end else begin
      bus.pred_hit    <= lk_hit;
      bus.pred_taken  <= lk_hit && lk_sel.ctr[BTB_CTR_W-1];
      bus.pred_target <= lk_hit ? lk_sel.target : '0;
    end
  end

endmodule
